display_refresh_sequencer: RTL and testbench

- Upstream timing stage of the seven-segment driver.
- Produces the 4-bit refresh state `q` consumed by the anode decoder. Anode decoding: q=1110→AN3, 1010→AN2, 0110→AN1, 0010→AN0, all other q values blank.
- Selects the 4-bit character for the digit currently addressed, for the cathode decoder.
- Holds a double-buffered 16-bit display frame, loaded through a valid/ready handshake and committed only at frame boundaries, so a frame never tears.

---
 rtl/seg_display_pkg.sv | 28 ++
 rtl/display_refresh_sequencer_if.sv | 18 +
 rtl/refresh_prescaler.sv | 30 +++
 rtl/display_refresh_sequencer.sv | 107 ++++++++++
 tb/tb_display_refresh_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_display_pkg.sv
// Shared definitions for the seven-segment display path: reset/refresh codes,
// frame geometry, the anode-active q codes and the frame buffer state type.
package seg_display_pkg;

  localparam logic [3:0] Q_RESET    = 4'b1111;
  localparam int         DIGIT_W    = 4;
  localparam int         NUM_DIGITS = 4;
  localparam int         FRAME_W    = 16;

  // q codes during which each anode is driven; every other code is blanking.
  localparam logic [3:0] Q_AN3 = 4'b1110;
  localparam logic [3:0] Q_AN2 = 4'b1010;
  localparam logic [3:0] Q_AN1 = 4'b0110;
  localparam logic [3:0] Q_AN0 = 4'b0010;

  // Pending (back) buffer occupancy.
  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Character of digit idx within a frame (digit 0 in the low nibble).
  function automatic logic [DIGIT_W-1:0] digit_of(input logic [FRAME_W-1:0] frame,
                                                  input logic [1:0] idx);
    return frame[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/display_refresh_sequencer_if.sv
// Frame load channel.
// Handshake: a transfer happens on a rising clk edge where load_valid and
// load_ready are both 1. While load_ready is 0 the sink ignores load_valid and
// the source keeps load_data stable. buf_state mirrors the pending-buffer FSM
// so a checker can observe it.
interface display_refresh_sequencer_if;
  import seg_display_pkg::*;

  logic [FRAME_W-1:0] load_data;
  logic               load_valid;
  logic               load_ready;
  buf_state_t         buf_state;

  modport master (output load_data, output load_valid,
                  input  load_ready, input  buf_state);
  modport slave  (input  load_data, input  load_valid,
                  output load_ready, output buf_state);
endinterface

// File: rtl/refresh_prescaler.sv
// Divides the system clock down to the refresh step rate: tick is high for
// one enabled cycle out of every PRESCALE enabled cycles.
module refresh_prescaler #(
  parameter int PRESCALE = 2500
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] count;

  // Terminal count while running marks the end of a q step.
  assign tick = enable && (count == PW'(PRESCALE - 1));

  // Count enabled cycles, restarting at each tick; hold while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + PW'(1);
    end
  end

endmodule

// File: rtl/display_refresh_sequencer.sv
// Refresh sequencer for the seven-segment driver: steps q down through 16
// states per frame, selects the addressed digit's character, and holds a
// double-buffered frame that only changes at the frame wrap.
module display_refresh_sequencer
  import seg_display_pkg::*;
#(
  parameter int PRESCALE = 2500
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  display_refresh_sequencer_if.slave   load,
  output logic [3:0]                   q,
  output logic [DIGIT_W-1:0]           digit_char,
  output logic                         frame_start
);

  logic               tick;
  logic               wrap;
  logic               accept;
  logic               commit;
  buf_state_t         buf_state;
  buf_state_t         buf_next;
  logic [FRAME_W-1:0] display;
  logic [FRAME_W-1:0] pending;

  refresh_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // The step out of q=0000 is the frame boundary.
  assign wrap = tick && (q == 4'b0000);

  // Pending-buffer FSM: fill on an accepted load, drain into the display at
  // the frame wrap. Accept and commit live in different states, so they can
  // never coincide.
  always_comb begin
    buf_next = buf_state;
    accept   = 1'b0;
    commit   = 1'b0;
    case (buf_state)
      BUF_EMPTY: begin
        if (load.load_valid) begin
          accept   = 1'b1;
          buf_next = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (wrap) begin
          commit   = 1'b1;
          buf_next = BUF_EMPTY;
        end
      end
      default: buf_next = BUF_EMPTY;
    endcase
  end

  // Buffer state register; reset drops any half-delivered frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_state <= BUF_EMPTY;
    end else begin
      buf_state <= buf_next;
    end
  end

  // Frame buffers: capture into pending on accept, copy to display on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      display <= '0;
    end else begin
      if (accept) begin
        pending <= load.load_data;
      end
      if (commit) begin
        display <= pending;
      end
    end
  end

  // Refresh state counts down one step per tick; frame_start marks the
  // first cycle back at 1111 after a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      q           <= Q_RESET;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        q <= q - 4'd1;
      end
    end
  end

  // load_ready comes straight from the buffer state flop.
  assign load.load_ready = (buf_state == BUF_EMPTY);
  assign load.buf_state  = buf_state;

  // q[3:2] addresses the digit, so its character is stable during the
  // blanking state ahead of each anode-active code.
  assign digit_char = digit_of(display, q[3:2]);

endmodule

// File: tb/tb_display_refresh_sequencer.sv
// Bench for display_refresh_sequencer: two instances (PRESCALE=4 and
// PRESCALE=1) share stimulus. A directed table exercises the frame/handshake
// corners on the PRESCALE=4 instance, and a cycle-count reference model
// checks both instances every cycle, including a randomized phase.
module tb_display_refresh_sequencer;
  import seg_display_pkg::*;

  // ---------------- clock / reset / shared stimulus ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0000;

  always #5 clk = ~clk;

  display_refresh_sequencer_if lif_a ();
  display_refresh_sequencer_if lif_b ();

  assign lif_a.load_data  = load_data;
  assign lif_a.load_valid = load_valid;
  assign lif_b.load_data  = load_data;
  assign lif_b.load_valid = load_valid;

  logic [3:0] q_a, q_b, dig_a, dig_b;
  logic       fs_a, fs_b;

  display_refresh_sequencer #(.PRESCALE(4)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .load(lif_a.slave),
    .q(q_a), .digit_char(dig_a), .frame_start(fs_a)
  );

  display_refresh_sequencer #(.PRESCALE(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .load(lif_b.slave),
    .q(q_b), .digit_char(dig_b), .frame_start(fs_b)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in the refresh is just the number of enabled cycles since
  // reset: q = 15 - (cycles / PRESCALE) mod 16.
  int          m_ps [2] = '{4, 1};
  int          m_cnt [2];
  logic [15:0] m_disp [2];
  logic [15:0] m_pend [2];
  bit          m_full [2];
  bit          m_fs [2];
  bit          live = 1'b0;

  function automatic bit m_tick(input int k);
    return enable && ((m_cnt[k] % m_ps[k]) == m_ps[k] - 1);
  endfunction

  function automatic bit m_wrap(input int k);
    return m_tick(k) && (((m_cnt[k] / m_ps[k]) % 16) == 15);
  endfunction

  function automatic logic [3:0] m_q(input int k);
    return 4'(15 - ((m_cnt[k] / m_ps[k]) % 16));
  endfunction

  function automatic logic [3:0] m_dig(input int k);
    logic [3:0]  qq;
    logic [15:0] f;
    qq = m_q(k);
    f  = m_disp[k] >> (4 * int'(qq[3:2]));
    return f[3:0];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cnt[k]  <= 0;
        m_disp[k] <= 16'h0000;
        m_full[k] <= 1'b0;
        m_fs[k]   <= 1'b0;
      end else begin
        m_fs[k] <= m_wrap(k);
        if (m_wrap(k) && m_full[k]) begin
          m_disp[k] <= m_pend[k];
          m_full[k] <= 1'b0;
        end else if (load_valid && !m_full[k]) begin
          m_pend[k] <= load_data;
          m_full[k] <= 1'b1;
        end
        if (enable) m_cnt[k] <= m_cnt[k] + 1;
      end
    end
    if (reset) live <= 1'b1;
  end

  // Every cycle, both instances against the model.
  always @(negedge clk) begin
    if (live) begin
      check("model_a", {22'd0, q_a, lif_a.load_ready, dig_a, fs_a},
            {22'd0, m_q(0), !m_full[0], m_dig(0), m_fs[0]});
      check("model_b", {22'd0, q_b, lif_b.load_ready, dig_b, fs_b},
            {22'd0, m_q(1), !m_full[1], m_dig(1), m_fs[1]});
    end
  end

  // ---------------- directed vector table (PRESCALE=4 instance) ----------------
  typedef struct {
    bit          rst;
    bit          en;
    bit          vld;
    logic [15:0] data;
    int          n;
    logic [3:0]  q;
    bit          rdy;
    logic [3:0]  dig;
    bit          fs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit en, bit vld, logic [15:0] data, int n,
                              logic [3:0] q, bit rdy, logic [3:0] dig, bit fs);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.data = data; v.n = n;
    v.q = q; v.rdy = rdy; v.dig = dig; v.fs = fs;
    return v;
  endfunction

  task automatic drive(input bit rst, input bit en, input bit vld, input logic [15:0] data);
    reset      = rst;
    enable     = en;
    load_valid = vld;
    load_data  = data;
  endtask

  int fs_cnt_a;
  int fs_cnt_b;

  initial begin
    // reset, then free-running refresh
    tbl.push_back(mk(1, 0, 0, 16'h0000,  1, 4'd15, 1, 4'h0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000,  1, 4'd15, 1, 4'h0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 24, 4'd9,  1, 4'h0, 0));
    // load 1234 at q=9: old frame stays until the wrap
    tbl.push_back(mk(0, 1, 1, 16'h1234,  1, 4'd9,  0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 37, 4'd0,  0, 4'h0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000,  1, 4'd15, 1, 4'h1, 1));
    tbl.push_back(mk(0, 1, 0, 16'h0000,  1, 4'd15, 1, 4'h1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000,  3, 4'd14, 1, 4'h1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000,  8, 4'd12, 1, 4'h1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000,  4, 4'd11, 1, 4'h2, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 16, 4'd7,  1, 4'h3, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 16, 4'd3,  1, 4'h4, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 15, 4'd0,  1, 4'h4, 0));
    // wrap with nothing pending keeps the frame
    tbl.push_back(mk(0, 1, 0, 16'h0000,  1, 4'd15, 1, 4'h1, 1));
    // ABCD accepted, 5678 held with valid until after the commit
    tbl.push_back(mk(0, 1, 1, 16'hABCD,  1, 4'd15, 0, 4'h1, 0));
    tbl.push_back(mk(0, 1, 1, 16'h5678, 62, 4'd0,  0, 4'h4, 0));
    tbl.push_back(mk(0, 1, 1, 16'h5678,  1, 4'd15, 1, 4'hA, 1));
    tbl.push_back(mk(0, 1, 1, 16'h5678,  1, 4'd15, 0, 4'hA, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 27, 4'd8,  0, 4'hB, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 36, 4'd15, 1, 4'h5, 1));
    // freeze at q=6, prescaler=2, with a frame pending
    tbl.push_back(mk(0, 1, 1, 16'h2468,  1, 4'd15, 0, 4'h5, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 37, 4'd6,  0, 4'h7, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 10, 4'd6,  0, 4'h7, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000,  1, 4'd6,  0, 4'h7, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000,  1, 4'd5,  0, 4'h7, 0));
    // freeze right at the wrap point: no commit until it resumes
    tbl.push_back(mk(0, 1, 0, 16'h0000, 23, 4'd0,  0, 4'h8, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0000,  8, 4'd0,  0, 4'h8, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000,  1, 4'd15, 1, 4'h2, 1));
    // reset at q=3 with 1357 pending: it is never shown
    tbl.push_back(mk(0, 1, 1, 16'h1357,  1, 4'd15, 0, 4'h2, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 48, 4'd3,  0, 4'h8, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000,  1, 4'd15, 1, 4'h0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 63, 4'd0,  1, 4'h0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0000,  1, 4'd15, 1, 4'h0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].data);
      repeat (tbl[i].n) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d{q,rdy,dig,fs}", i),
            {22'd0, q_a, lif_a.load_ready, dig_a, fs_a},
            {22'd0, tbl[i].q, tbl[i].rdy, tbl[i].dig, tbl[i].fs});
    end

    // frame_start rate: one pulse per 16*PRESCALE enabled cycles
    drive(1, 0, 0, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 0, 16'h0000);
    fs_cnt_a = 0;
    fs_cnt_b = 0;
    repeat (160) begin
      @(posedge clk);
      @(negedge clk);
      if (fs_a) fs_cnt_a++;
      if (fs_b) fs_cnt_b++;
    end
    check("fs_count_p4", 32'(fs_cnt_a), 32'd2);
    check("fs_count_p1", 32'(fs_cnt_b), 32'd10);

    // randomized phase, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 8),
            $urandom_range(0, 1) == 1, 16'($urandom));
      @(posedge clk);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
